fixed_point_divider_seq: RTL
============================

// Module: fixed_point_divider_seq
// PURPOSE
//   Iterative signed Q16.16 divider, the inverse of the datapath's combinational Q16.16 multiplier.
//   Computes q = (a << FRACT_BITS) / b by radix-2 restoring division on magnitudes, one quotient bit/cycle.
//   Sits beside the multiplier in the fixed-point arithmetic unit; valid/ready on both input and output sides.
//   Flags divide-by-zero and overflow; saturates the result in both cases.
// PARAMETERS
//   WIDTH       32  operand/result width (two's complement, Q(WIDTH-FRACT_BITS).FRACT_BITS)
//   FRACT_BITS  16  fractional bits; iteration count ITERS = WIDTH + FRACT_BITS (48 at defaults)
// PORTS
//   clk           in   1      clock, all state updates on rising edge
//   rst           in   1      synchronous, active-high reset
//   in_valid      in   1      dividend/divisor valid
//   in_ready      out  1      block can accept operands (high only in IDLE)
//   a_in          in   WIDTH  dividend, signed Q16.16
//   b_in          in   WIDTH  divisor, signed Q16.16
//   out_valid     out  1      q_out/flags valid; held until out_ready
//   out_ready     in   1      downstream accepts the result
//   q_out         out  WIDTH  quotient, signed Q16.16
//   overflow      out  1      true quotient outside range; q_out saturated
//   div_by_zero   out  1      b_in was 0; q_out saturated
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, q_out=0, overflow=0, div_by_zero=0, counter/regs cleared.
//   Reset mid-operation aborts the division; no result is emitted. in_ready=1 the cycle after rst deasserts.
//   FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready, register sign=a[MSB]^b[MSB], |a|, |b| (WIDTH-bit unsigned,
//     so |0x80000000| = 2^31), dividend = |a| << FRACT_BITS (WIDTH+FRACT_BITS bits), remainder=0.
//     If b_in==0: go directly to DONE, div_by_zero=1, overflow=0,
//     q_out = 0x7FFFFFFF if a_in>=0 (including a=0), else 0x80000000.
//     Else go to CALC, counter=ITERS-1.
//   CALC: per cycle, shift remainder (WIDTH+1 bits) left, bring in next dividend MSB; if rem>=|b|,
//     subtract and shift 1 into quotient, else shift 0. Leave CALC after ITERS iterations.
//     Inputs ignored while not in IDLE (in_ready=0).
//   Result: magnitude quotient Qm (WIDTH+FRACT_BITS bits), truncated toward zero (remainder discarded).
//     sign=0: Qm > 2^(WIDTH-1)-1 -> q_out=0x7FFFFFFF, overflow=1; else q_out=Qm.
//     sign=1: Qm > 2^(WIDTH-1)   -> q_out=0x80000000, overflow=1; else q_out=-Qm (two's complement).
//     Zero quotient with sign=1 yields 0 (no negative zero).
//   DONE: out_valid=1; q_out/flags stable until out_valid&out_ready; then IDLE, out_valid=0 next cycle.
//     Flags are meaningful only while out_valid=1; cleared on leaving DONE.
//   Latency: accept edge at cycle T -> out_valid high at T+ITERS+1 (49); div-by-zero -> T+1.
//   No accept in the cycle of an output handshake; max throughput one op per ITERS+2 cycles.
// TESTING
//   1.5/0.5: a=0x00018000, b=0x00008000 -> q=0x00030000, flags 0, out_valid exactly 49 cycles after accept.
//   -3.0/2.0: a=0xFFFD0000, b=0x00020000 -> q=0xFFFE8000; 1/3: 0x00010000/0x00030000 -> 0x00005555;
//     -1/3: 0xFFFF0000/0x00030000 -> 0xFFFFAAAB (truncation toward zero).
//   Div by zero: a=0x00010000, b=0 -> q=0x7FFFFFFF, div_by_zero=1, 1-cycle latency; a=0xFFFF0000, b=0 -> 0x80000000.
//   Overflow/limits: 0x7FFF0000/0x00000100 -> 0x7FFFFFFF, overflow=1;
//     0x80000000/0x00010000 -> 0x80000000, overflow=0; 0x80000000/0xFFFF0000 -> 0x7FFFFFFF, overflow=1.
//   Backpressure: hold out_ready=0 for 10 cycles -> out_valid and q_out stable, in_ready=0;
//     in_valid pulses during CALC are ignored.
//   Reset at iteration 20 -> out_valid=0, in_ready=1 after reset; next op 1.5/0.5 returns 0x00030000.

Source files
------------

// File: rtl/fixed_point_divider_seq_if.sv
// fixed_point_divider_seq_if: operand/result valid-ready bundle for the Q16.16 divider
interface fixed_point_divider_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q_out;
  logic             overflow;
  logic             div_by_zero;
  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, q_out, overflow, div_by_zero
  );
  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, q_out, overflow, div_by_zero
  );
endinterface

// File: rtl/fixed_point_divider_seq.sv
// fixed_point_divider_seq: iterative signed fixed-point divider, one restoring quotient bit per cycle
module fixed_point_divider_seq #(
  parameter int WIDTH      = 32,
  parameter int FRACT_BITS = 16
) (
  input logic clk,
  input logic rst,
  fixed_point_divider_seq_if.slave bus_io
);
  localparam int ITERS = WIDTH + FRACT_BITS;
  localparam int CW    = $clog2(ITERS);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ITERS-1:0] MAXP = {{(FRACT_BITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [ITERS-1:0] MAXN = {{FRACT_BITS{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q;
  logic             sign_q;
  logic [WIDTH-1:0] bmag_q;
  logic [ITERS-1:0] dvd_q;
  logic [WIDTH:0]   rem_q;
  logic [ITERS-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             ovf_q;
  logic             dbz_q;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH:0]   rem_d;
  logic [ITERS-1:0] quo_d;
  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic             ovf_d;
  logic [WIDTH-1:0] res_d;
  assign bus_io.in_ready    = state_q == IDLE;
  assign bus_io.out_valid   = state_q == DONE;
  assign bus_io.q_out       = q_q;
  assign bus_io.overflow    = ovf_q;
  assign bus_io.div_by_zero = dbz_q;
  // One restoring step plus operand magnitudes and the saturated, signed final result.
  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], dvd_q[ITERS-1]};
    ge     = rem_sh >= {1'b0, bmag_q};
    rem_d  = ge ? rem_sh - {1'b0, bmag_q} : rem_sh;
    quo_d  = {quo_q[ITERS-2:0], ge};
    amag   = bus_io.a_in[WIDTH-1] ? -bus_io.a_in : bus_io.a_in;
    bmag   = bus_io.b_in[WIDTH-1] ? -bus_io.b_in : bus_io.b_in;
    ovf_d  = sign_q ? quo_d > MAXN : quo_d > MAXP;
    res_d  = ovf_d ? (sign_q ? MINV : MAXV) : (sign_q ? -quo_d[WIDTH-1:0] : quo_d[WIDTH-1:0]);
  end
  // Control FSM and datapath registers; the result is latched on the final iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      bmag_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus_io.in_valid) begin
          sign_q <= bus_io.a_in[WIDTH-1] ^ bus_io.b_in[WIDTH-1];
          bmag_q <= bmag;
          dvd_q  <= {amag, {FRACT_BITS{1'b0}}};
          rem_q  <= '0;
          quo_q  <= '0;
          cnt_q  <= CW'(ITERS - 1);
          if (bus_io.b_in == '0) begin
            state_q <= DONE;
            dbz_q   <= 1'b1;
            ovf_q   <= 1'b0;
            q_q     <= bus_io.a_in[WIDTH-1] ? MINV : MAXV;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          dvd_q <= {dvd_q[ITERS-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= DONE;
            q_q     <= res_d;
            ovf_q   <= ovf_d;
          end
        end
        DONE: if (bus_io.out_ready) begin
          state_q <= IDLE;
          ovf_q   <= 1'b0;
          dbz_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
